// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with flush bubbles, en_reg hold and a bounded multicycle freeze.
// Optional frozen-edge counter on stall_cnt when ID_EX_PIPE_PERF_CNT_EN is defined.
module id_ex_pipe #(
  parameter int CTRL_W   = 8,
  parameter int DATA_W   = 32,
  parameter int REG_W    = 5,
  parameter int HOLD_MAX = 32,
  parameter int CNT_W    = $clog2(HOLD_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_reg,
  input  logic              flush,
  input  logic              mc_start,
  input  logic [CNT_W-1:0]  mc_len,
  input  logic              valid_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [4:0]        shamt_in,
  input  logic [5:0]        funct_in,
  input  logic [DATA_W-1:0] RD1_in,
  input  logic [DATA_W-1:0] RD2_in,
  input  logic [DATA_W-1:0] immed_in,
  input  logic [REG_W-1:0]  rt_in,
  input  logic [REG_W-1:0]  rd_in,
  output logic              valid_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [4:0]        shamt_out,
  output logic [5:0]        funct_out,
  output logic [DATA_W-1:0] RD1_out,
  output logic [DATA_W-1:0] RD2_out,
  output logic [DATA_W-1:0] immed_out,
  output logic [REG_W-1:0]  rt_out,
  output logic [REG_W-1:0]  rd_out,
  output logic              mc_busy,
  output logic [15:0]       stall_cnt
);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  localparam logic [CNT_W-1:0] HOLD_MAX_C = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

  function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] len);
    return (len > HOLD_MAX_C) ? HOLD_MAX_C : len;
  endfunction

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [4:0]        r_shamt;
  logic [5:0]        r_funct;
  logic [DATA_W-1:0] r_rd1;
  logic [DATA_W-1:0] r_rd2;
  logic [DATA_W-1:0] r_immed;
  logic [REG_W-1:0]  r_rt;
  logic [REG_W-1:0]  r_rd;

  logic              w_mc_accept;
  logic [CNT_W-1:0]  w_len;

  assign w_mc_accept = (r_state == S_IDLE) && mc_start && (mc_len != '0);
  assign w_len       = clamp_len(mc_len);

  // The request edge itself is the first frozen edge, so HOLD counts the remaining N-1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_shamt <= '0;
      r_funct <= '0;
      r_rd1   <= '0;
      r_rd2   <= '0;
      r_immed <= '0;
      r_rt    <= '0;
      r_rd    <= '0;
    end else if (flush) begin
      r_ctrl  <= '0;
      r_valid <= 1'b0;
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else if (r_state == S_HOLD) begin
      if (r_cnt <= ONE_C) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_busy  <= 1'b0;
      end else begin
        r_cnt <= r_cnt - ONE_C;
      end
    end else if (w_mc_accept) begin
      r_cnt <= w_len - ONE_C;
      if (w_len > ONE_C) begin
        r_state <= S_HOLD;
        r_busy  <= 1'b1;
      end
    end else if (en_reg) begin
      r_valid <= valid_in;
      r_ctrl  <= ctrl_in;
      r_shamt <= shamt_in;
      r_funct <= funct_in;
      r_rd1   <= RD1_in;
      r_rd2   <= RD2_in;
      r_immed <= immed_in;
      r_rt    <= rt_in;
      r_rd    <= rd_in;
    end
  end

  assign valid_out = r_valid;
  assign ctrl_out  = r_ctrl;
  assign shamt_out = r_shamt;
  assign funct_out = r_funct;
  assign RD1_out   = r_rd1;
  assign RD2_out   = r_rd2;
  assign immed_out = r_immed;
  assign rt_out    = r_rt;
  assign rd_out    = r_rd;
  assign mc_busy   = r_busy;

`ifdef ID_EX_PIPE_PERF_CNT_EN
  logic        w_frozen;
  logic [15:0] r_stall;

  // Flush edges are bubbles, not stalls, so they never count.
  assign w_frozen = !flush && ((r_state == S_HOLD) || w_mc_accept || !en_reg);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall <= '0;
    end else if (w_frozen && (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign stall_cnt = r_stall;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: directed vector table, hand sequences and random vs a model.
module tb_id_ex_pipe;

  localparam int CTRL_W   = 8;
  localparam int DATA_W   = 32;
  localparam int REG_W    = 5;
  localparam int HOLD_MAX = 32;
  localparam int CNT_W    = 6;

  logic              clk;
  logic              rst;
  logic              en_reg;
  logic              flush;
  logic              mc_start;
  logic [CNT_W-1:0]  mc_len;
  logic              valid_in;
  logic [CTRL_W-1:0] ctrl_in;
  logic [4:0]        shamt_in;
  logic [5:0]        funct_in;
  logic [DATA_W-1:0] RD1_in, RD2_in, immed_in;
  logic [REG_W-1:0]  rt_in, rd_in;
  logic              valid_out;
  logic [CTRL_W-1:0] ctrl_out;
  logic [4:0]        shamt_out;
  logic [5:0]        funct_out;
  logic [DATA_W-1:0] RD1_out, RD2_out, immed_out;
  logic [REG_W-1:0]  rt_out, rd_out;
  logic              mc_busy;
  logic [15:0]       stall_cnt;

  id_ex_pipe #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .REG_W(REG_W), .HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .rst(rst), .en_reg(en_reg), .flush(flush),
    .mc_start(mc_start), .mc_len(mc_len),
    .valid_in(valid_in), .ctrl_in(ctrl_in), .shamt_in(shamt_in), .funct_in(funct_in),
    .RD1_in(RD1_in), .RD2_in(RD2_in), .immed_in(immed_in), .rt_in(rt_in), .rd_in(rd_in),
    .valid_out(valid_out), .ctrl_out(ctrl_out), .shamt_out(shamt_out), .funct_out(funct_out),
    .RD1_out(RD1_out), .RD2_out(RD2_out), .immed_out(immed_out), .rt_out(rt_out), .rd_out(rd_out),
    .mc_busy(mc_busy), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the visible register contents plus "frozen edges still owed".
  logic              m_valid;
  logic [CTRL_W-1:0] m_ctrl;
  logic [4:0]        m_shamt;
  logic [5:0]        m_funct;
  logic [DATA_W-1:0] m_rd1, m_rd2, m_imm;
  logic [REG_W-1:0]  m_rt, m_rd;
  int                m_left  = 0;
  int                m_stall = 0;

  task automatic bump_stall();
`ifdef ID_EX_PIPE_PERF_CNT_EN
    if (m_stall < 65535) m_stall++;
`endif
  endtask

  task automatic model_edge();
    int n;
    if (!rst) begin
      m_valid = 0; m_ctrl = 0; m_shamt = 0; m_funct = 0;
      m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_rt = 0; m_rd = 0;
      m_left = 0; m_stall = 0;
    end else if (flush) begin
      m_ctrl = 0; m_valid = 0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      bump_stall();
    end else if (mc_start && mc_len != 0) begin
      n = (int'(mc_len) > HOLD_MAX) ? HOLD_MAX : int'(mc_len);
      m_left = n - 1;
      bump_stall();
    end else if (en_reg) begin
      m_valid = valid_in; m_ctrl = ctrl_in; m_shamt = shamt_in; m_funct = funct_in;
      m_rd1 = RD1_in; m_rd2 = RD2_in; m_imm = immed_in; m_rt = rt_in; m_rd = rd_in;
    end else begin
      bump_stall();
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, 64'(valid_out), 64'(m_valid));
    check({tag, ".ctrl"},  64'(ctrl_out),  64'(m_ctrl));
    check({tag, ".shamt"}, 64'(shamt_out), 64'(m_shamt));
    check({tag, ".funct"}, 64'(funct_out), 64'(m_funct));
    check({tag, ".RD1"},   64'(RD1_out),   64'(m_rd1));
    check({tag, ".RD2"},   64'(RD2_out),   64'(m_rd2));
    check({tag, ".immed"}, 64'(immed_out), 64'(m_imm));
    check({tag, ".rt"},    64'(rt_out),    64'(m_rt));
    check({tag, ".rd"},    64'(rd_out),    64'(m_rd));
    check({tag, ".busy"},  64'(mc_busy),   64'(m_left > 0));
    check({tag, ".stall"}, 64'(stall_cnt), 64'(m_stall));
  endtask

  typedef struct {
    logic        rst, en, fl, mcs;
    logic [5:0]  mcl;
    logic [31:0] rd1;
    logic [7:0]  ctl;
    logic [31:0] e_rd1;
    logic [7:0]  e_ctl;
    logic        e_vld, e_busy;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic e, input logic f, input logic s,
                              input logic [5:0] l, input logic [31:0] d, input logic [7:0] c,
                              input logic [31:0] ed, input logic [7:0] ec,
                              input logic ev, input logic eb);
    vec_t v;
    v.rst = r; v.en = e; v.fl = f; v.mcs = s; v.mcl = l; v.rd1 = d; v.ctl = c;
    v.e_rd1 = ed; v.e_ctl = ec; v.e_vld = ev; v.e_busy = eb;
    return v;
  endfunction

  vec_t tbl [19];

  initial begin
    int frozen, busy_edges;
    logic [31:0] held;

    //            rst en fl mcs len data          ctl     exp data      ctl    v  busy
    tbl[0]  = mk(0, 1, 0, 0, 0, 32'h11111111, 8'hAA, 32'h0,        8'h00, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 0, 32'h22222222, 8'hBB, 32'h0,        8'h00, 0, 0);
    tbl[2]  = mk(1, 1, 0, 0, 0, 32'hDEADBEEF, 8'h5A, 32'hDEADBEEF, 8'h5A, 1, 0);
    tbl[3]  = mk(1, 0, 0, 0, 0, 32'h1,        8'h01, 32'hDEADBEEF, 8'h5A, 1, 0);
    tbl[4]  = mk(1, 1, 0, 1, 4, 32'h2,        8'h02, 32'hDEADBEEF, 8'h5A, 1, 1);
    tbl[5]  = mk(1, 1, 0, 0, 0, 32'h3,        8'h03, 32'hDEADBEEF, 8'h5A, 1, 1);
    tbl[6]  = mk(1, 1, 0, 1, 4, 32'h4,        8'h04, 32'hDEADBEEF, 8'h5A, 1, 1);
    tbl[7]  = mk(1, 1, 0, 0, 0, 32'h5,        8'h05, 32'hDEADBEEF, 8'h5A, 1, 0);
    tbl[8]  = mk(1, 1, 0, 0, 0, 32'h6,        8'h06, 32'h6,        8'h06, 1, 0);
    tbl[9]  = mk(1, 1, 0, 1, 1, 32'h7,        8'h07, 32'h6,        8'h06, 1, 0);
    tbl[10] = mk(1, 1, 0, 0, 0, 32'h8,        8'h08, 32'h8,        8'h08, 1, 0);
    tbl[11] = mk(1, 1, 0, 1, 0, 32'h9,        8'h09, 32'h9,        8'h09, 1, 0);
    tbl[12] = mk(1, 1, 0, 1, 3, 32'hA,        8'h0A, 32'h9,        8'h09, 1, 1);
    tbl[13] = mk(1, 1, 1, 0, 0, 32'hB,        8'h0B, 32'h9,        8'h00, 0, 0);
    tbl[14] = mk(1, 1, 0, 0, 0, 32'hC,        8'h0C, 32'hC,        8'h0C, 1, 0);
    tbl[15] = mk(1, 1, 1, 0, 0, 32'hD,        8'h0D, 32'hC,        8'h00, 0, 0);
    tbl[16] = mk(1, 1, 0, 1, 4, 32'hE,        8'h0E, 32'hC,        8'h00, 0, 1);
    tbl[17] = mk(0, 1, 0, 0, 0, 32'h10,       8'h10, 32'h0,        8'h00, 0, 0);
    tbl[18] = mk(1, 1, 0, 0, 0, 32'hF,        8'h0F, 32'hF,        8'h0F, 1, 0);

    rst = 0; en_reg = 0; flush = 0; mc_start = 0; mc_len = 0;
    valid_in = 1; ctrl_in = 0; shamt_in = 5'd3; funct_in = 6'd9;
    RD1_in = 0; RD2_in = 32'h12345678; immed_in = 32'hCAFEF00D; rt_in = 5'd7; rd_in = 5'd21;
    @(negedge clk);

    for (int i = 0; i < 19; i++) begin
      rst = tbl[i].rst; en_reg = tbl[i].en; flush = tbl[i].fl;
      mc_start = tbl[i].mcs; mc_len = tbl[i].mcl; RD1_in = tbl[i].rd1; ctrl_in = tbl[i].ctl;
      step();
      check($sformatf("vec%0d.RD1", i),   64'(RD1_out),   64'(tbl[i].e_rd1));
      check($sformatf("vec%0d.ctrl", i),  64'(ctrl_out),  64'(tbl[i].e_ctl));
      check($sformatf("vec%0d.valid", i), 64'(valid_out), 64'(tbl[i].e_vld));
      check($sformatf("vec%0d.busy", i),  64'(mc_busy),   64'(tbl[i].e_busy));
    end
    rst = 1; flush = 0;

    // mc_len beyond HOLD_MAX is clamped to exactly HOLD_MAX frozen edges.
    held = RD1_out;
    en_reg = 1; mc_start = 1; mc_len = 6'd40; RD1_in = 32'h100;
    step();
    mc_start = 0;
    frozen = (RD1_out == held) ? 1 : 0;
    busy_edges = mc_busy ? 1 : 0;
    for (int i = 0; i < 100; i++) begin
      RD1_in = 32'h200 + 32'(i);
      step();
      if (RD1_out != held) break;
      frozen++;
      if (mc_busy) busy_edges++;
    end
    check("clamp40.frozen_edges", 64'(frozen), 64'(HOLD_MAX));
    check("clamp40.busy_edges",   64'(busy_edges), 64'(HOLD_MAX - 1));

    // Stall counter: three en_reg=0 edges plus a 4-edge hold.
    rst = 0; step();
    rst = 1; en_reg = 0;
    for (int i = 0; i < 3; i++) step();
    en_reg = 1; mc_start = 1; mc_len = 6'd4;
    step();
    mc_start = 0;
    for (int i = 0; i < 3; i++) step();
`ifdef ID_EX_PIPE_PERF_CNT_EN
    check("stall.after_7", 64'(stall_cnt), 64'd7);
`else
    check("stall.disabled", 64'(stall_cnt), 64'd0);
`endif
    check_all("stall_seq");

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 59) != 0);
      flush    = ($urandom_range(0, 15) == 0);
      en_reg   = ($urandom_range(0, 3) != 0);
      mc_start = ($urandom_range(0, 7) == 0);
      mc_len   = ($urandom_range(0, 9) == 0) ? CNT_W'($urandom_range(33, 63))
                                              : CNT_W'($urandom_range(0, 8));
      valid_in = 1'($urandom);
      ctrl_in  = 8'($urandom);
      shamt_in = 5'($urandom);
      funct_in = 6'($urandom);
      RD1_in   = $urandom;
      RD2_in   = $urandom;
      immed_in = $urandom;
      rt_in    = 5'($urandom);
      rd_in    = 5'($urandom);
      step();
      check_all($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 Parameter CTRL_W, default 8, width of packed control bundle {WB[1:0],MEM[1:0],EX[3:0]}.
REQ-002 Parameter DATA_W, default 32, width of RD1/RD2/immed fields.
REQ-003 Parameter REG_W, default 5, width of rt/rd register-index fields.
REQ-004 Parameter HOLD_MAX, default 32, maximum multicycle hold length; CNT_W = clog2(HOLD_MAX+1).
REQ-005 clk  input  1  sole clock; all state updates on posedge clk.
REQ-006 rst  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-007 en_reg  input  1  stage advance enable; low = hold.
REQ-008 flush  input  1  insert bubble into stage.
REQ-009 mc_start  input  1  request multicycle hold of the current stage contents.
REQ-010 mc_len  input  CNT_W  hold length in clock edges, sampled with mc_start.
REQ-011 valid_in / valid_out  input / output  1  instruction-valid flag.
REQ-012 ctrl_in / ctrl_out  input / output  CTRL_W  control bundle.
REQ-013 shamt_in / shamt_out  5; funct_in / funct_out  6; RD1, RD2, immed _in/_out  DATA_W; rt, rd _in/_out  REG_W; all registered pass-through fields.
REQ-014 mc_busy  output  1  registered, high while in HOLD state.
REQ-015 stall_cnt  output  16  frozen-edge counter (see Configuration).

Function
REQ-016 Two states: IDLE, HOLD; hold counter cnt, CNT_W bits.
REQ-017 Edge priority, highest first: reset, flush, multicycle hold, en_reg capture, hold.
REQ-018 Capture: IDLE, no flush, no mc_start (or mc_len==0), en_reg=1 -> every _out takes its _in value, latency 1 edge.
REQ-019 en_reg=0 in IDLE with no flush/mc_start -> all outputs hold.
REQ-020 Flush edge (any state) -> ctrl_out=0, valid_out=0, other data outputs hold, state IDLE, cnt=0, mc_busy=0.
REQ-021 IDLE, mc_start=1, mc_len=N, 1<=N<=HOLD_MAX -> outputs frozen this edge, cnt<=N-1, state HOLD if N>1 else stay IDLE.
REQ-022 mc_len > HOLD_MAX is clamped to HOLD_MAX; mc_len==0 -> mc_start ignored, normal capture rules apply.
REQ-023 HOLD: outputs frozen regardless of en_reg; cnt decrements each edge; edge with cnt==1 -> state IDLE, cnt=0.
REQ-024 Total frozen edges for a request of N is exactly N; first en_reg capture occurs on edge N+1.
REQ-025 mc_start while in HOLD is ignored; no restart or extension.
REQ-026 mc_busy=1 exactly while state==HOLD.

Reset
REQ-027 rst=0 at posedge clk -> all data/control outputs 0, valid_out=0, mc_busy=0, state IDLE, cnt=0, stall_cnt=0.
REQ-028 Reset mid-HOLD aborts the hold; first edge after rst returns high follows REQ-018 rules.

Configuration
REQ-029 Macro ID_EX_PIPE_PERF_CNT_EN defined -> stall_cnt increments on every edge where outputs are frozen by REQ-019/021/023 (flush edges excluded), saturating at 16'hFFFF.
REQ-030 Macro undefined -> stall_cnt is constant 0 and no counter logic is generated; all other behaviour identical.

Verification
REQ-031 rst=0 two edges, inputs nonzero -> all outputs 0, mc_busy=0; release, en_reg=1, RD1_in=32'hDEADBEEF -> RD1_out=32'hDEADBEEF after 1 edge.
REQ-032 IDLE, mc_start=1, mc_len=4, en_reg held 1, inputs changing -> outputs frozen 4 edges, mc_busy high edges 1-3, new capture on edge 5.
REQ-033 mc_len=1 -> exactly one frozen edge, mc_busy never asserts; mc_len=0 -> normal capture; mc_len=40 with HOLD_MAX=32 -> 32 frozen edges.
REQ-034 Flush during HOLD with cnt=2 -> next edge ctrl_out=0, valid_out=0, mc_busy=0; flush with en_reg=1 -> bubble wins over capture.
REQ-035 rst=0 mid-HOLD -> state IDLE, outputs 0; second mc_start during HOLD -> no extension.
REQ-036 With ID_EX_PIPE_PERF_CNT_EN: 3 en_reg=0 edges + mc_len=4 hold -> stall_cnt=7; without macro -> stall_cnt=0.
